// File: rtl/alu_stream.sv
// ============================================================================
// Module   : alu_stream
// Purpose  : Valid/ready streaming ALU with an iterative one-bit-per-cycle
//            shifter for shift amounts of two or more.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_stream #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zf,
    output logic             cf,
    output logic             of,
    output logic             ill
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_not  = 4'd2;
    localparam logic [3:0] c_op_and  = 4'd3;
    localparam logic [3:0] c_op_or   = 4'd4;
    localparam logic [3:0] c_op_xor  = 4'd5;
    localparam logic [3:0] c_op_slt  = 4'd6;
    localparam logic [3:0] c_op_eq   = 4'd7;
    localparam logic [3:0] c_op_sltu = 4'd8;
    localparam logic [3:0] c_op_sll  = 4'd9;
    localparam logic [3:0] c_op_srl  = 4'd10;
    localparam logic [3:0] c_op_sra  = 4'd11;

    // Shift direction is the low two opcode bits: 01 SLL, 10 SRL, 11 SRA.
    localparam logic [1:0] c_dir_sll = 2'b01;
    localparam logic [1:0] c_dir_srl = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic [1:0]       dir_q,       dir_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic             zf_q,        zf_d;
    logic             cf_q,        cf_d;
    logic             of_q,        of_d;
    logic             ill_q,       ill_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [32:0]      w_b_ext;
    logic [CW-1:0]    w_n;
    logic             w_is_shift;
    logic             w_long_shift;
    logic [WIDTH-1:0] w_alu_y;
    logic             w_alu_zf;
    logic             w_alu_cf;
    logic             w_alu_of;
    logic             w_alu_ill;
    logic             w_accept;
    logic             w_deliver;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       dir);
        case (dir)
            c_dir_sll: shift1 = {v[WIDTH-2:0], 1'b0};
            c_dir_srl: shift1 = {1'b0, v[WIDTH-1:1]};
            default:   shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = a - b;
    assign w_b_ext = 33'(b);

    // Saturating the amount at WIDTH keeps the counter narrow and gives the
    // all-zero / all-sign result naturally after WIDTH single-bit steps.
    assign w_n          = (w_b_ext >= 33'(WIDTH)) ? CW'(WIDTH) : CW'(b);
    assign w_is_shift   = (op == c_op_sll) || (op == c_op_srl) || (op == c_op_sra);
    assign w_long_shift = w_is_shift && (w_n >= CW'(2));

    always_comb begin
        w_alu_y   = '0;
        w_alu_cf  = 1'b0;
        w_alu_of  = 1'b0;
        w_alu_ill = 1'b0;
        case (op)
            c_op_add: begin
                w_alu_y  = w_sum[WIDTH-1:0];
                w_alu_cf = w_sum[WIDTH];
                w_alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_y  = w_diff;
                w_alu_cf = (a < b);
                w_alu_of = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_not:  w_alu_y = ~a;
            c_op_and:  w_alu_y = a & b;
            c_op_or:   w_alu_y = a | b;
            c_op_xor:  w_alu_y = a ^ b;
            c_op_slt:  w_alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_eq:   w_alu_y = {{(WIDTH-1){1'b0}}, (a == b)};
            c_op_sltu: w_alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
            c_op_sll, c_op_srl, c_op_sra:
                w_alu_y = (w_n == '0) ? a : shift1(a, op[1:0]);
            default:   w_alu_ill = 1'b1;
        endcase
        w_alu_zf = !w_alu_ill && (w_alu_y == '0);
    end

    assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q && !w_deliver;
        y_d         = y_q;
        zf_d        = zf_q;
        cf_d        = cf_q;
        of_d        = of_q;
        ill_d       = ill_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_long_shift) begin
                        work_d  = a;
                        cnt_d   = w_n;
                        dir_d   = op[1:0];
                        state_d = ST_SHIFT;
                    end else begin
                        out_valid_d = 1'b1;
                        y_d         = w_alu_y;
                        zf_d        = w_alu_zf;
                        cf_d        = w_alu_cf;
                        of_d        = w_alu_of;
                        ill_d       = w_alu_ill;
                    end
                end
            end
            default: begin
                if (cnt_q > CW'(1)) begin
                    work_d = shift1(work_q, dir_q);
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    y_d         = shift1(work_q, dir_q);
                    zf_d        = (shift1(work_q, dir_q) == '0);
                    cf_d        = 1'b0;
                    of_d        = 1'b0;
                    ill_d       = 1'b0;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dir_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            of_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zf_q        <= zf_d;
            cf_q        <= cf_d;
            of_q        <= of_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign of        = of_q;
    assign ill       = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_stream.sv
// ============================================================================
// Module   : tb_alu_stream
// Purpose  : Randomized and directed bench for alu_stream against an
//            arithmetic reference model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_stream;

    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, y;
    logic         zf, cf, of, ill;

    logic         in_valid4, in_ready4, out_valid4;
    logic [3:0]   op4, a4, b4, y4;
    logic         zf4, cf4, of4, ill4;

    alu_stream #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zf(zf), .cf(cf), .of(of), .ill(ill)
    );

    alu_stream #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(1'b1),
        .y(y4), .zf(zf4), .cf(cf4), .of(of4), .ill(ill4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W+3:0] res;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    bit   last_acc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result word {y, zf, cf, of, ill} plus the extra cycles a multi-step shift needs.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] z, output logic [W+3:0] res,
                                  output int extra);
        int   ux, uz, sx, sz, r, n;
        logic fz, fc, fo, fi;
        ux = int'(x);
        uz = int'(z);
        sx = (ux >= HALF) ? ux - FULL : ux;
        sz = (uz >= HALF) ? uz - FULL : uz;
        fc = 1'b0; fo = 1'b0; fi = 1'b0; extra = 0; r = 0;
        case (o)
            4'd0: begin r = ux + uz; fc = (r >= FULL); fo = (sx + sz >= HALF) || (sx + sz < -HALF); end
            4'd1: begin r = ux - uz; fc = (ux < uz);   fo = (sx - sz >= HALF) || (sx - sz < -HALF); end
            4'd2: r = FULL - 1 - ux;
            4'd3: r = ux & uz;
            4'd4: r = ux | uz;
            4'd5: r = ux ^ uz;
            4'd6: r = (sx < sz) ? 1 : 0;
            4'd7: r = (ux == uz) ? 1 : 0;
            4'd8: r = (ux < uz) ? 1 : 0;
            4'd9, 4'd10, 4'd11: begin
                n     = (uz > W) ? W : uz;
                extra = (n >= 2) ? n : 0;
                if (o == 4'd9)       r = ux << n;
                else if (o == 4'd10) r = ux >> n;
                else                 r = sx >>> n;
            end
            default: fi = 1'b1;
        endcase
        r   = r & (FULL - 1);
        fz  = !fi && (r == 0);
        res = {W'(r), fz, fc, fo, fi};
    endfunction

    // One clock: check in_ready before the edge, update the scoreboard at the
    // edge, then check the registered outputs just after it.
    task automatic tick();
        logic         exp_rdy, acc, del, rst_edge, exp_ov;
        logic [W+3:0] res;
        int           extra;
        #1;
        exp_rdy = rst_n && ((q.size() == 0) || (cyc >= q[0].due && out_ready));
        check("in_ready", in_ready, exp_rdy);
        acc      = in_valid && in_ready;
        del      = out_valid && out_ready;
        rst_edge = !rst_n;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (rst_edge) begin
            q.delete();
        end else begin
            if (del && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                model(op, a, b, res, extra);
                q.push_back('{res, cyc + extra});
            end
        end
        #1;
        if (rst_edge) check("rst_outputs", {out_valid, y, zf, cf, of, ill}, 0);
        exp_ov = (q.size() > 0) && (cyc >= q[0].due);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) check("result", {y, zf, cf, of, ill}, q[0].res);
    endtask

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        int k;
        in_valid = 1'b1; op = o; a = x; b = z;
        k = 0;
        tick();
        while (!last_acc && k < 20) begin
            tick();
            k++;
        end
        check("send_accept", last_acc, 1);
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run4(input string tag, input logic [3:0] o, input logic [3:0] x,
                        input logic [3:0] z, input logic [7:0] exp);
        op4 = o; a4 = x; b4 = z; in_valid4 = 1'b1;
        #1;
        check({tag, "_rdy"}, in_ready4, 1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        check(tag, {out_valid4, y4, zf4, cf4, of4, ill4}, {1'b1, exp});
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // 4-bit arithmetic flags: {y, zf, cf, of, ill}
        run4("add4_of",    4'd0, 4'h7, 4'h1, {4'h8, 4'b0010});
        run4("add4_carry", 4'd0, 4'hF, 4'h1, {4'h0, 4'b1100});
        run4("sub4_borrow",4'd1, 4'h0, 4'h1, {4'hF, 4'b0100});

        // back-to-back single-cycle ops
        send(4'd3, 8'hF0, 8'h0F);
        check("and_zero", {y, zf}, {8'h00, 1'b1});
        send(4'd4, 8'hA0, 8'h05);
        send(4'd5, 8'h3C, 8'hFF);
        send(4'd6, 8'h80, 8'h01);
        check("slt_signed", y, 8'h01);
        send(4'd8, 8'h80, 8'h01);
        check("sltu_unsigned", y, 8'h00);
        send(4'd7, 8'h42, 8'h42);
        send(4'd2, 8'h0F, 8'h00);
        in_valid = 1'b0;

        // iterative shifts
        send(4'd11, 8'h90, 8'd3);
        in_valid = 1'b0;
        wait_valid(20, k);
        check("sra_latency", k, 3);
        check("sra_value", y, 8'hF2);
        send(4'd9, 8'h5A, 8'd200);
        in_valid = 1'b0;
        wait_valid(20, k);
        check("sll_big_latency", k, 8);
        check("sll_big_value", {y, zf}, {8'h00, 1'b1});
        tick();

        // backpressure with a pending beat
        out_ready = 1'b0;
        send(4'd0, 8'h12, 8'h34);
        in_valid = 1'b1; op = 4'd5; a = 8'hFF; b = 8'h0F;
        for (int i = 0; i < 5; i++) tick();
        check("bp_hold_y", y, 8'h46);
        check("bp_hold_rdy", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("bp_same_edge_accept", last_acc, 1);
        check("bp_new_result", {out_valid, y}, {1'b1, 8'hF0});
        in_valid = 1'b0;

        // illegal opcode, then a legal one clears ill
        send(4'd13, 8'h55, 8'hAA);
        check("illegal_op", {y, zf, cf, of, ill}, {8'h00, 4'b0001});
        send(4'd0, 8'h01, 8'h01);
        check("ill_cleared", {y, ill}, {8'h02, 1'b0});
        in_valid = 1'b0;
        tick();

        // reset in the middle of a shift
        send(4'd9, 8'h01, 8'd7);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rst_abort", {out_valid, y, zf, cf, of, ill}, 0);
        send(4'd0, 8'h20, 8'h22);
        check("post_rst_add", {out_valid, y}, {1'b1, 8'h42});
        in_valid = 1'b0;

        // randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op       = 4'($urandom_range(0, 15));
                a        = W'($urandom);
                b        = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 9));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
